uart_rx_ctrl: RTL and testbench

//  Receive-side controller between uart_rx and the APB register file. Accepts each character

---
 rtl/uart_rx_ctrl_pkg.sv | 46 ++++
 rtl/uart_rx_ctrl_if.sv | 34 +++
 rtl/uart_rx_ctrl_fifo.sv | 70 +++++++
 rtl/uart_rx_ctrl.sv | 172 +++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_ctrl_pkg
// Shared types and helpers for the receive-side controller.
//   trig_e      : encoding of the FIFO trigger-level selector
//   char_bits() : bits per character frame (start + data + parity + stop)
//   trig_level(): trigger threshold clamped to the physical FIFO depth
//   lvl_width() : width of a fill-level count for a given depth
// -----------------------------------------------------------------------------
package uart_rx_ctrl_pkg;

   typedef enum logic [1:0] {
      TRIG_1  = 2'b00,
      TRIG_4  = 2'b01,
      TRIG_8  = 2'b10,
      TRIG_14 = 2'b11
   } trig_e;

   localparam int DATA_W  = 8;
   localparam int ENTRY_W = DATA_W + 1;
   localparam int PRESC_W = 20;
   localparam int TICK_W  = 6;

   // Frame length: one start bit, 5..8 data bits, optional parity, one stop.
   function automatic logic [3:0] char_bits(input logic [1:0] bits, input logic parity);
      return 4'd7 + {2'b00, bits} + {3'b000, parity};
   endfunction

   // Threshold for the data interrupt; a small FIFO can never hold 14 entries,
   // so the level saturates at the FIFO depth.
   function automatic logic [8:0] trig_level(input trig_e trig, input int depth);
      logic [8:0] lvl;
      case (trig)
         TRIG_1:  lvl = 9'd1;
         TRIG_4:  lvl = 9'd4;
         TRIG_8:  lvl = 9'd8;
         default: lvl = 9'd14;
      endcase
      if (int'(lvl) > depth) lvl = 9'(depth);
      return lvl;
   endfunction

   function automatic int lvl_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// -----------------------------------------------------------------------------
// uart_rx_ctrl_if
// Character link between uart_rx (master) and uart_rx_ctrl (slave).
//   rx_data    : received character
//   rx_valid   : character valid for one cycle
//   rx_ready   : controller accepts the character
//   rx_err     : sticky parity error held by uart_rx
//   rx_err_clr : one-cycle pulse that clears rx_err in uart_rx
// -----------------------------------------------------------------------------
interface uart_rx_ctrl_if import uart_rx_ctrl_pkg::*; ();

   logic [DATA_W-1:0] rx_data;
   logic              rx_valid;
   logic              rx_ready;
   logic              rx_err;
   logic              rx_err_clr;

   modport master (
      output rx_data,
      output rx_valid,
      output rx_err,
      input  rx_ready,
      input  rx_err_clr
   );

   modport slave (
      input  rx_data,
      input  rx_valid,
      input  rx_err,
      output rx_ready,
      output rx_err_clr
   );

endinterface

// File: rtl/uart_rx_ctrl_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// DEPTH x 9 first-word-fall-through storage: data byte plus parity-error bit.
//   clk_i, rstn_i : clock, async active-low reset
//   flush_i       : empty the FIFO (wins over push/pop)
//   push_i        : write wdata_i at the tail (caller guarantees room)
//   pop_i         : drop the head (caller guarantees not empty)
//   wdata_i       : {err, data} to write
//   tag_last_i    : set the err bit of the most recently written slot
//   rdata_o       : head entry, zero when empty
//   count_o       : registered fill level
// -----------------------------------------------------------------------------
module uart_rx_fifo import uart_rx_ctrl_pkg::*; #(
   parameter int DEPTH = 16
) (
   input  logic                     clk_i,
   input  logic                     rstn_i,
   input  logic                     flush_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [ENTRY_W-1:0]       wdata_i,
   input  logic                     tag_last_i,
   output logic [ENTRY_W-1:0]       rdata_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [ENTRY_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]      r_wr_ptr;
   logic [AW-1:0]      r_rd_ptr;
   logic [LW-1:0]      r_count;
   logic [AW-1:0]      w_last_ptr;

   assign w_last_ptr = r_wr_ptr - AW'(1);

   // Storage has no reset: slots are only visible once written, and the
   // output is forced to zero while empty. The tag never targets the slot
   // being written in the same cycle, because the tail sits one past it.
   always_ff @(posedge clk_i) begin
      if (push_i) r_mem[r_wr_ptr] <= wdata_i;
      if (tag_last_i) r_mem[w_last_ptr][ENTRY_W-1] <= 1'b1;
   end

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (push_i) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (pop_i)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({push_i, pop_i})
            2'b10:   r_count <= r_count + LW'(1);
            2'b01:   r_count <= r_count - LW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign rdata_o = (r_count == '0) ? '0 : r_mem[r_rd_ptr];
   assign count_o = r_count;

endmodule

// File: rtl/uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_ctrl
// Receive-side controller between uart_rx and the APB register file. Buffers
// characters with a parity-error tag, raises trigger-level and character-
// timeout interrupts, tracks overrun and clears the receiver's sticky error.
//   clk_i, rstn_i   : clock, async active-low reset
//   rx_if (slave)   : character link from uart_rx
//   cfg_div_i       : baud divisor, bit period = cfg_div_i*16 clocks
//   cfg_bits_i      : data bits minus 5
//   cfg_parity_en_i : parity bit present in the frame
//   cfg_fifo_en_i   : 1 = FIFO mode, 0 = single holding register
//   cfg_trig_i      : trigger level 1/4/8/14
//   fifo_clr_i      : flush pulse
//   rd_i            : pop pulse
//   rd_data_o/rd_err_o : head character and its parity flag
//   rx_lvl_o, data_ready_o : fill level and non-empty flag
//   overrun_o, ovr_clr_i   : sticky overrun and its clear
//   irq_data_o, irq_timeout_o : interrupt sources
// -----------------------------------------------------------------------------
module uart_rx_ctrl import uart_rx_ctrl_pkg::*; #(
   parameter int DEPTH = 16
) (
   input  logic                   clk_i,
   input  logic                   rstn_i,
   uart_rx_ctrl_if.slave          rx_if,
   input  logic [15:0]            cfg_div_i,
   input  logic [1:0]             cfg_bits_i,
   input  logic                   cfg_parity_en_i,
   input  logic                   cfg_fifo_en_i,
   input  logic [1:0]             cfg_trig_i,
   input  logic                   fifo_clr_i,
   input  logic                   rd_i,
   output logic [DATA_W-1:0]      rd_data_o,
   output logic                   rd_err_o,
   output logic [$clog2(DEPTH):0] rx_lvl_o,
   output logic                   data_ready_o,
   output logic                   overrun_o,
   input  logic                   ovr_clr_i,
   output logic                   irq_data_o,
   output logic                   irq_timeout_o
);

   localparam int LW = lvl_width(DEPTH);

   logic [LW-1:0]      w_lvl;
   logic [LW-1:0]      w_cap;
   logic               w_full;
   logic               w_empty;
   logic               w_flush;
   logic               w_pop;
   logic               w_push;
   logic               w_drop;
   logic               w_err_edge;
   logic               w_tag_new;
   logic               w_tag_last;
   logic [ENTRY_W-1:0] w_wdata;
   logic [ENTRY_W-1:0] w_head;
   logic               w_to_run;
   logic               w_to_clr;
   logic [PRESC_W-1:0] w_period_m1;
   logic               w_tick;
   logic [TICK_W-1:0]  w_target;
   logic [TICK_W-1:0]  w_ticks_nx;

   logic               r_fifo_en_d;
   logic               r_err_d;
   logic               r_err_clr;
   logic               r_tag_valid;
   logic               r_ovr;
   logic [PRESC_W-1:0] r_presc;
   logic [TICK_W-1:0]  r_ticks;
   logic               r_tmo;

   assign w_cap   = cfg_fifo_en_i ? LW'(DEPTH) : LW'(1);
   assign w_full  = (w_lvl >= w_cap);
   assign w_empty = (w_lvl == '0);

   // A mode switch invalidates whatever is buffered, so it behaves as a flush.
   assign w_flush = fifo_clr_i | (cfg_fifo_en_i ^ r_fifo_en_d);

   // A pop frees a slot in the same cycle, so push+pop on a full FIFO is legal.
   assign w_pop  = rd_i & ~w_empty & ~w_flush;
   assign w_push = rx_if.rx_valid & ~w_flush & (~w_full | w_pop);
   assign w_drop = rx_if.rx_valid & ~w_flush & w_full & ~w_pop;

   // An error edge coinciding with a push belongs to the incoming character;
   // otherwise it goes to the tail, provided the tail is the last accepted
   // character and it survives this cycle.
   assign w_err_edge = rx_if.rx_err & ~r_err_d;
   assign w_tag_new  = w_err_edge & w_push;
   assign w_tag_last = w_err_edge & ~w_push & ~w_drop & ~w_flush & r_tag_valid
                       & ~w_empty & ~(w_pop & (w_lvl == LW'(1)));
   assign w_wdata    = {w_tag_new, rx_if.rx_data};

   uart_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_i      (clk_i),
      .rstn_i     (rstn_i),
      .flush_i    (w_flush),
      .push_i     (w_push),
      .pop_i      (w_pop),
      .wdata_i    (w_wdata),
      .tag_last_i (w_tag_last),
      .rdata_o    (w_head),
      .count_o    (w_lvl)
   );

   // Edge detection on the receiver's sticky error, the clear pulse back to
   // uart_rx, and tracking whether the tail is still the last accepted char.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_fifo_en_d <= 1'b0;
         r_err_d     <= 1'b0;
         r_err_clr   <= 1'b0;
         r_tag_valid <= 1'b0;
      end else begin
         r_fifo_en_d <= cfg_fifo_en_i;
         r_err_d     <= rx_if.rx_err;
         r_err_clr   <= w_err_edge;
         if (w_flush || w_drop) r_tag_valid <= 1'b0;
         else if (w_push)       r_tag_valid <= 1'b1;
      end
   end

   // Sticky overrun; a new overrun beats a clear arriving in the same cycle.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i)        r_ovr <= 1'b0;
      else if (w_drop)    r_ovr <= 1'b1;
      else if (ovr_clr_i) r_ovr <= 1'b0;
   end

   assign w_to_run    = cfg_fifo_en_i & (cfg_div_i != 16'd0) & ~w_empty;
   assign w_to_clr    = w_push | w_pop | w_flush | ~w_to_run;
   assign w_period_m1 = {cfg_div_i, 4'b0000} - PRESC_W'(1);
   assign w_tick      = (r_presc >= w_period_m1);
   assign w_target    = {char_bits(cfg_bits_i, cfg_parity_en_i), 2'b00};
   assign w_ticks_nx  = r_ticks + TICK_W'(1);

   // Character timeout: count bit periods of FIFO inactivity up to four
   // character times. Counting freezes once the interrupt is pending.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_presc <= '0;
         r_ticks <= '0;
         r_tmo   <= 1'b0;
      end else if (w_to_clr) begin
         r_presc <= '0;
         r_ticks <= '0;
         r_tmo   <= 1'b0;
      end else if (!r_tmo) begin
         if (w_tick) begin
            r_presc <= '0;
            r_ticks <= w_ticks_nx;
            if (w_ticks_nx == w_target) r_tmo <= 1'b1;
         end else begin
            r_presc <= r_presc + PRESC_W'(1);
         end
      end
   end

   assign rx_if.rx_ready   = 1'b1;
   assign rx_if.rx_err_clr = r_err_clr;
   assign rd_data_o        = w_head[DATA_W-1:0];
   assign rd_err_o         = w_head[ENTRY_W-1];
   assign rx_lvl_o         = w_lvl;
   assign data_ready_o     = ~w_empty;
   assign overrun_o        = r_ovr;
   assign irq_timeout_o    = r_tmo;
   assign irq_data_o       = cfg_fifo_en_i
                             ? (9'(w_lvl) >= trig_level(trig_e'(cfg_trig_i), DEPTH))
                             : ~w_empty;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_ctrl
// Directed bench for uart_rx_ctrl (DEPTH=16): ordering and trigger interrupt,
// full/overrun/flush behaviour, parity tagging, character timeout, holding-
// register mode and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_uart_rx_ctrl;
   import uart_rx_ctrl_pkg::*;

   logic        clk;
   logic        rstn;
   logic [15:0] cfgDiv;
   logic [1:0]  cfgBits;
   logic        cfgParity;
   logic        cfgFifoEn;
   logic [1:0]  cfgTrig;
   logic        fifoClr;
   logic        rd;
   logic [7:0]  rdData;
   logic        rdErr;
   logic [4:0]  lvl;
   logic        dataReady;
   logic        overrun;
   logic        ovrClr;
   logic        irqData;
   logic        irqTimeout;

   int total = 0;
   int bad   = 0;
   int cnt;

   uart_rx_ctrl_if rx_if ();

   uart_rx_ctrl #(.DEPTH(16)) dut (
      .clk_i           (clk),
      .rstn_i          (rstn),
      .rx_if           (rx_if),
      .cfg_div_i       (cfgDiv),
      .cfg_bits_i      (cfgBits),
      .cfg_parity_en_i (cfgParity),
      .cfg_fifo_en_i   (cfgFifoEn),
      .cfg_trig_i      (cfgTrig),
      .fifo_clr_i      (fifoClr),
      .rd_i            (rd),
      .rd_data_o       (rdData),
      .rd_err_o        (rdErr),
      .rx_lvl_o        (lvl),
      .data_ready_o    (dataReady),
      .overrun_o       (overrun),
      .ovr_clr_i       (ovrClr),
      .irq_data_o      (irqData),
      .irq_timeout_o   (irqTimeout)
   );

   // Free-running 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One comparison: counts it, and on mismatch counts and reports it.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of character/pop inputs from a falling edge to the next.
   task automatic applyStimulus(input logic v, input logic [7:0] d, input logic r);
      rx_if.rx_valid = v;
      rx_if.rx_data  = d;
      rd             = r;
      @(negedge clk);
      rx_if.rx_valid = 1'b0;
      rx_if.rx_data  = 8'h00;
      rd             = 1'b0;
   endtask

   // Directed sequence.
   initial begin
      rstn = 1'b0; cfgDiv = 16'd1; cfgBits = 2'd3; cfgParity = 1'b0;
      cfgFifoEn = 1'b1; cfgTrig = 2'b01; fifoClr = 1'b0; rd = 1'b0; ovrClr = 1'b0;
      rx_if.rx_valid = 1'b0; rx_if.rx_data = 8'h00; rx_if.rx_err = 1'b0;
      repeat (3) @(negedge clk);

      $display("[TB] reset state");
      checkOutput("rst ready", rx_if.rx_ready, 1);
      checkOutput("rst lvl", lvl, 0);
      checkOutput("rst dready", dataReady, 0);
      checkOutput("rst ovr", overrun, 0);
      checkOutput("rst irqdata", irqData, 0);
      checkOutput("rst irqtmo", irqTimeout, 0);
      checkOutput("rst rddata", rdData, 0);
      checkOutput("rst errclr", rx_if.rx_err_clr, 0);
      rstn = 1'b1;
      repeat (2) @(negedge clk);

      $display("[TB] test 1: trigger level 4 and ordering");
      applyStimulus(1'b1, 8'h41, 1'b0);
      applyStimulus(1'b1, 8'h42, 1'b0);
      applyStimulus(1'b1, 8'h43, 1'b0);
      checkOutput("t1 lvl3", lvl, 3);
      checkOutput("t1 irq below trig", irqData, 0);
      applyStimulus(1'b1, 8'h44, 1'b0);
      checkOutput("t1 lvl4", lvl, 4);
      checkOutput("t1 irq at trig", irqData, 1);
      checkOutput("t1 dready", dataReady, 1);
      for (int i = 0; i < 4; i++) begin
         checkOutput("t1 head", rdData, 32'h41 + i);
         applyStimulus(1'b0, 8'h00, 1'b1);
         checkOutput("t1 lvl after pop", lvl, 3 - i);
         if (i == 0) checkOutput("t1 irq after pop", irqData, 0);
      end
      checkOutput("t1 empty data", rdData, 0);
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("t1 pop empty lvl", lvl, 0);
      checkOutput("t1 dready empty", dataReady, 0);

      $display("[TB] test 2/5: full, overrun, push+pop, flush");
      for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'h10 + 8'(i), 1'b0);
      checkOutput("t2 lvl full", lvl, 16);
      checkOutput("t2 ovr before", overrun, 0);
      checkOutput("t2 head", rdData, 8'h10);
      applyStimulus(1'b1, 8'h99, 1'b1);
      checkOutput("t5 push+pop ovr", overrun, 0);
      checkOutput("t5 push+pop lvl", lvl, 16);
      checkOutput("t5 head", rdData, 8'h11);
      applyStimulus(1'b1, 8'hEE, 1'b0);
      checkOutput("t2 ovr set", overrun, 1);
      checkOutput("t2 lvl after drop", lvl, 16);
      checkOutput("t2 head after drop", rdData, 8'h11);
      fifoClr = 1'b1;
      @(negedge clk);
      fifoClr = 1'b0;
      checkOutput("t5 flush lvl", lvl, 0);
      checkOutput("t5 flush ovr kept", overrun, 1);
      checkOutput("t5 flush data", rdData, 0);
      ovrClr = 1'b1;
      @(negedge clk);
      ovrClr = 1'b0;
      checkOutput("t2 ovr cleared", overrun, 0);

      $display("[TB] test 3: parity tag");
      applyStimulus(1'b1, 8'h55, 1'b0);
      checkOutput("t3 err before", rdErr, 0);
      rx_if.rx_err = 1'b1;
      @(negedge clk);
      checkOutput("t3 clr pulse", rx_if.rx_err_clr, 1);
      checkOutput("t3 err tagged", rdErr, 1);
      rx_if.rx_err = 1'b0;
      @(negedge clk);
      checkOutput("t3 clr one cycle", rx_if.rx_err_clr, 0);
      applyStimulus(1'b1, 8'h66, 1'b0);
      checkOutput("t3 head 55", rdData, 8'h55);
      checkOutput("t3 head err", rdErr, 1);
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("t3 head 66", rdData, 8'h66);
      checkOutput("t3 66 clean", rdErr, 0);
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("t3 lvl 0", lvl, 0);

      $display("[TB] test 4: character timeout");
      applyStimulus(1'b1, 8'h77, 1'b0);
      cnt = 0;
      while (!irqTimeout && cnt < 1000) begin
         @(negedge clk);
         cnt++;
      end
      $display("[TB] timeout after %0d cycles", cnt);
      checkOutput("t4 latency in window", (cnt >= 638 && cnt <= 642), 1);
      checkOutput("t4 tmo set", irqTimeout, 1);
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("t4 tmo cleared", irqTimeout, 0);
      checkOutput("t4 lvl 0", lvl, 0);

      $display("[TB] test 6: holding register mode and async reset");
      cfgFifoEn = 1'b0;
      repeat (2) @(negedge clk);
      applyStimulus(1'b1, 8'hA1, 1'b0);
      checkOutput("t6 lvl 1", lvl, 1);
      checkOutput("t6 irq lvl1", irqData, 1);
      checkOutput("t6 ovr before", overrun, 0);
      ovrClr = 1'b1;
      applyStimulus(1'b1, 8'hA2, 1'b0);
      ovrClr = 1'b0;
      checkOutput("t6 ovr set wins", overrun, 1);
      checkOutput("t6 lvl stays 1", lvl, 1);
      checkOutput("t6 head A1", rdData, 8'hA1);
      rx_if.rx_valid = 1'b1;
      rx_if.rx_data  = 8'hB0;
      #2 rstn = 1'b0;
      #1;
      checkOutput("t6 arst lvl", lvl, 0);
      checkOutput("t6 arst ovr", overrun, 0);
      @(negedge clk);
      rx_if.rx_valid = 1'b0;
      checkOutput("t6 arst dready", dataReady, 0);
      checkOutput("t6 arst data", rdData, 0);
      checkOutput("t6 arst irq", irqData, 0);
      checkOutput("t6 arst ready", rx_if.rx_ready, 1);
      rstn = 1'b1;
      repeat (2) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
